// File: rtl/syscall_pkg.sv
// Shared types and constants for the console-read syscall unit.
// Holds the FSM state enum, syscall codes, ASCII constants and a digit test.
package syscall_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_CHAR  = 3'd1,
        RD_SIGN  = 3'd2,
        RD_DIGIT = 3'd3,
        DONE     = 3'd4,
        WAIT_CLR = 3'd5
    } state_e;

    localparam int unsigned SYS_PRINT_INT = 32'd1;
    localparam int unsigned SYS_READ_INT  = 32'd5;
    localparam int unsigned SYS_EXIT      = 32'd10;
    localparam int unsigned SYS_READ_CHAR = 32'd12;

    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_NINE    = 8'h39;
    localparam logic [7:0] ASCII_MINUS   = 8'h2D;
    localparam logic [7:0] ASCII_NEWLINE = 8'h0A;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/syscall_dec_accum.sv
// Decimal accumulator: acc = acc*10 + digit with a digit counter.
// Digits past MAX_DIGITS are dropped and raise a sticky overflow until cleared.
module syscall_dec_accum
    import syscall_pkg::*;
#(
    parameter int MAX_DIGITS = 10,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              step,
    input  logic [3:0]        digit,
    output logic [DATA_W-1:0] acc,
    output logic              overflow
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic [DATA_W-1:0] acc_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;
    logic [DATA_W-1:0] acc_next_s;

    // Shift-add form of x10; wraps modulo 2^DATA_W
    assign acc_next_s = (acc_r << 3) + (acc_r << 1) + DATA_W'(digit);

    // Accumulator, digit count and overflow flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r      <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else if (clear) begin
            acc_r      <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else if (step) begin
            if (count_r < CNT_W'(MAX_DIGITS)) begin
                acc_r   <= acc_next_s;
                count_r <= count_r + CNT_W'(1);
            end else begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign acc      = acc_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/syscall_reader.sv
// Console read syscall unit: stalls the CPU, parses read_char / read_int input bytes.
// Define SYSCALL_READER_TRACE_EN to print each completed result.
module syscall_reader
    import syscall_pkg::*;
#(
    parameter int MAX_DIGITS = 10,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              syscall_control,
    input  logic [DATA_W-1:0] v0,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              stall,
    output logic              result_valid,
    output logic [DATA_W-1:0] result,
    output logic              overflow
);

    state_e            state_r, next_state_s;
    logic [DATA_W-1:0] result_r, result_d_s;
    logic              result_valid_r;
    logic              negate_r;
    logic              load_result_s, acc_clear_s, acc_step_s, neg_set_s;
    logic              in_read_s, is_read_code_s;
    logic [DATA_W-1:0] acc_s;
    logic              overflow_s;

    syscall_dec_accum #(
        .MAX_DIGITS(MAX_DIGITS),
        .DATA_W    (DATA_W)
    ) u_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (acc_clear_s),
        .step    (acc_step_s),
        .digit   (in_data[3:0]),
        .acc     (acc_s),
        .overflow(overflow_s)
    );

    assign in_read_s      = (state_r == RD_CHAR) || (state_r == RD_SIGN) || (state_r == RD_DIGIT);
    assign is_read_code_s = (v0 == DATA_W'(SYS_READ_INT)) || (v0 == DATA_W'(SYS_READ_CHAR));
    // Gating with syscall_control keeps a byte from being swallowed by an aborting read
    assign in_ready = rst_n && syscall_control && in_read_s;
    assign stall    = rst_n && (in_read_s || ((state_r == IDLE) && syscall_control && is_read_code_s));

    // Next-state and datapath control decode
    always_comb begin
        next_state_s  = state_r;
        result_d_s    = '0;
        load_result_s = 1'b0;
        acc_clear_s   = 1'b0;
        acc_step_s    = 1'b0;
        neg_set_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (syscall_control && (v0 == DATA_W'(SYS_READ_CHAR))) begin
                    next_state_s = RD_CHAR;
                    acc_clear_s  = 1'b1;
                end else if (syscall_control && (v0 == DATA_W'(SYS_READ_INT))) begin
                    next_state_s = RD_SIGN;
                    acc_clear_s  = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RD_CHAR: begin
                if (!syscall_control) begin
                    next_state_s = IDLE;
                end else if (in_valid) begin
                    result_d_s    = {{(DATA_W-8){1'b0}}, in_data};
                    load_result_s = 1'b1;
                    next_state_s  = DONE;
                end else begin
                    next_state_s = RD_CHAR;
                end
            end
            RD_SIGN: begin
                if (!syscall_control) begin
                    next_state_s = IDLE;
                end else if (in_valid) begin
                    if (in_data == ASCII_MINUS) begin
                        neg_set_s    = 1'b1;
                        next_state_s = RD_DIGIT;
                    end else if (is_digit(in_data)) begin
                        acc_step_s   = 1'b1;
                        next_state_s = RD_DIGIT;
                    end else begin
                        result_d_s    = '0;
                        load_result_s = 1'b1;
                        next_state_s  = DONE;
                    end
                end else begin
                    next_state_s = RD_SIGN;
                end
            end
            RD_DIGIT: begin
                if (!syscall_control) begin
                    next_state_s = IDLE;
                end else if (in_valid) begin
                    if (is_digit(in_data)) begin
                        acc_step_s   = 1'b1;
                        next_state_s = RD_DIGIT;
                    end else begin
                        result_d_s    = negate_r ? (DATA_W'(0) - acc_s) : acc_s;
                        load_result_s = 1'b1;
                        next_state_s  = DONE;
                    end
                end else begin
                    next_state_s = RD_DIGIT;
                end
            end
            DONE: begin
                next_state_s = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (!syscall_control) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WAIT_CLR;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, result, valid pulse and sign flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            result_r       <= '0;
            result_valid_r <= 1'b0;
            negate_r       <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            result_valid_r <= (next_state_s == DONE);
            if (load_result_s) begin
                result_r <= result_d_s;
            end
            if (acc_clear_s) begin
                negate_r <= 1'b0;
            end else if (neg_set_s) begin
                negate_r <= 1'b1;
            end
        end
    end

`ifdef SYSCALL_READER_TRACE_EN
    // Console trace of each completed read
    always_ff @(posedge clk) begin
        if (rst_n && (state_r == DONE)) begin
            $display("SYSCALL INPUT = %d", result_r);
        end
    end
`else
    // Tracing compiled out; ports and timing are unchanged
`endif

    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign overflow     = overflow_s;

endmodule

// File: tb/tb_syscall_reader.sv
// Self-checking bench for syscall_reader: scoreboard of expected results
// popped on each result_valid pulse, plus direct handshake/stall checks.
module tb_syscall_reader;
    import syscall_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        syscall_control = 1'b0;
    logic [31:0] v0 = 32'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready, stall, result_valid, overflow;
    logic [31:0] result;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic prev_valid = 1'b0;

    syscall_reader #(.MAX_DIGITS(10), .DATA_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .syscall_control(syscall_control),
        .v0             (v0),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .stall          (stall),
        .result_valid   (result_valid),
        .result         (result),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (result_valid) begin
            if (prev_valid) check_val("valid_one_cycle", 32'd1, 32'd0);
            if (sb.size() == 0) begin
                check_val("spurious_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("result", result, e.res);
                check_val("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                check_val("stall_in_done", {31'd0, stall}, 32'd0);
            end
        end
        prev_valid = result_valid;
    end

    task automatic start_call(input logic [31:0] code, input logic exp_stall);
        v0 = code;
        syscall_control = 1'b1;
        @(negedge clk);
        check_val("stall_on_decode", {31'd0, stall}, {31'd0, exp_stall});
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (n >= 40) check_val("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            if (i < s.len() - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    check_val("stall_in_gap", {31'd0, stall}, 32'd1);
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic expect_result(input logic [31:0] r, input logic o);
        exp_t e;
        e.res = r;
        e.ovf = o;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("result_seen", sb.size(), 32'd0);
    endtask

    task automatic end_call();
        @(posedge clk); #1;
        @(negedge clk);
        check_val("wait_clr_stall", {31'd0, stall}, 32'd0);
        check_val("wait_clr_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        syscall_control = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_result", result, 32'd0);
        check_val("rst_valid", {31'd0, result_valid}, 32'd0);
        check_val("rst_overflow", {31'd0, overflow}, 32'd0);
        check_val("rst_stall", {31'd0, stall}, 32'd0);
        check_val("rst_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // "123\n": valid one cycle after the terminator is accepted
        start_call(SYS_READ_INT, 1'b1);
        expect_result(32'd123, 1'b0);
        send_str("123\n", 0);
        @(negedge clk);
        check_val("valid_after_nl", {31'd0, result_valid}, 32'd1);
        wait_drain();
        end_call();
        check_val("result_holds", result, 32'd123);

        // "-42\n" with 3-cycle gaps
        start_call(SYS_READ_INT, 1'b1);
        expect_result(32'hFFFF_FFD6, 1'b0);
        send_str("-42\n", 3);
        wait_drain();
        end_call();

        // read_char consumes exactly one byte
        start_call(SYS_READ_CHAR, 1'b1);
        expect_result(32'h0000_0041, 1'b0);
        send_byte(8'h41);
        in_data  = 8'h42;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("char_no_second", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        wait_drain();
        @(posedge clk); #1;
        syscall_control = 1'b0;
        @(posedge clk); #1;

        // Overflow after MAX_DIGITS digits
        start_call(SYS_READ_INT, 1'b1);
        expect_result(32'd1234567890, 1'b1);
        send_str("12345678901\n", 0);
        wait_drain();
        end_call();

        // Reset mid-read, then a fresh read
        start_call(SYS_READ_INT, 1'b1);
        send_str("12", 0);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("rst_mid_ready", {31'd0, in_ready}, 32'd0);
        check_val("rst_mid_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        check_val("rst_mid_result", result, 32'd0);
        check_val("rst_mid_ovf", {31'd0, overflow}, 32'd0);
        syscall_control = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_call(SYS_READ_INT, 1'b1);
        expect_result(32'd7, 1'b0);
        send_str("7\n", 0);
        wait_drain();
        end_call();

        // Non-read syscalls are ignored
        start_call(SYS_PRINT_INT, 1'b0);
        @(negedge clk);
        check_val("print_ready", {31'd0, in_ready}, 32'd0);
        check_val("print_stall", {31'd0, stall}, 32'd0);
        syscall_control = 1'b0;
        @(posedge clk); #1;
        start_call(SYS_EXIT, 1'b0);
        @(negedge clk);
        check_val("exit_ready", {31'd0, in_ready}, 32'd0);
        syscall_control = 1'b0;
        @(posedge clk); #1;

        // Bare "-" then terminator yields 0; non-digit first byte yields 0
        start_call(SYS_READ_INT, 1'b1);
        expect_result(32'd0, 1'b0);
        send_str("-\n", 0);
        wait_drain();
        end_call();
        start_call(SYS_READ_INT, 1'b1);
        expect_result(32'd0, 1'b0);
        send_str("x", 0);
        wait_drain();
        end_call();

        // Abort mid-read: no result, back to idle
        start_call(SYS_READ_INT, 1'b1);
        send_str("9", 0);
        syscall_control = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("abort_stall", {31'd0, stall}, 32'd0);
        check_val("abort_ready", {31'd0, in_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("abort_result_kept", result, 32'd0);
        check_val("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
